// File: rtl/systolic_pkg.sv
// Shared types and defaults for the output-stationary systolic matrix-multiply engine.
// Holds the FSM state encoding and the sign-extension helper used by the MAC cells.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      FEED    = 3'd2,
      DRAIN   = 3'd3,
      READOUT = 3'd4
   } state_t;

   localparam int N_DEF      = 4;
   localparam int DATA_W_DEF = 16;
   localparam int ACC_W_DEF  = 32;
   localparam int K_MAX_DEF  = 16;

   // Products are widened through a fixed 64-bit carrier, so ACC_W must not exceed 64.
   localparam int SX_W  = 64;
   localparam int SX_LW = 6;

   // Sign-extend the low w bits of v to the full carrier width.
   function automatic logic [SX_W-1:0] sext(input logic [SX_W-1:0] v, input int unsigned w);
      logic [SX_W-1:0] m;
      m = {SX_W{1'b1}} << w;
      return v[SX_LW'(w - 1)] ? (v | m) : (v & ~m);
   endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One systolic processing element: registers operands east/south each cycle and
// accumulates the full signed product into a wrapping ACC_W accumulator.
module systolic_mac_pe
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);

   localparam int P_W = 2 * DATA_W;

   logic [P_W-1:0] prod;

   assign prod = $signed(a_in) * $signed(b_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         if (en) acc <= acc + ACC_W'(sext(SX_W'(prod), P_W));
      end
   end

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic engine computing C = A*B with runtime inner dimension,
// internal operand skewing, valid/ready streaming in and a serial row-major result read-out.
module systolic_mm_engine
   import systolic_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int K_MAX  = K_MAX_DEF,
   parameter int KW     = $clog2(K_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [KW-1:0]         k_len,
   output logic                  busy,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_W-1:0]   in_west,
   input  logic [N*DATA_W-1:0]   in_north,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic [$clog2(N)-1:0]  out_row,
   output logic [$clog2(N)-1:0]  out_col,
   output logic                  out_last,
   output logic                  done
);

   localparam int RW = $clog2(N);
   localparam int DW = $clog2(2 * N);

   state_t         state, nxt;
   logic [KW-1:0]  k_q, beat_cnt;
   logic [DW-1:0]  drn_cnt;
   logic [RW-1:0]  row, col;
   logic           done_q;
   logic           beat, hs, last_el, pe_clr, pe_en;

   logic [N-1:0][DATA_W-1:0]        w_lane, n_lane, w_sk, n_sk;
   logic [N-1:0][N-2:0][DATA_W-1:0] a_pass;
   logic [N-2:0][N-1:0][DATA_W-1:0] b_pass;
   logic [N-1:0][DATA_W-1:0]        a_east_unused, b_south_unused;
   logic [N-1:0][N-1:0][ACC_W-1:0]  acc;

   assign beat    = in_valid && (state == FEED);
   assign hs      = (state == READOUT) && out_ready;
   assign last_el = (row == RW'(N - 1)) && (col == RW'(N - 1));
   assign pe_clr  = (state == CLEAR);
   assign pe_en   = (state == FEED) || (state == DRAIN);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start && (k_len != '0) && !done_q) nxt = CLEAR;
         CLEAR:   nxt = FEED;
         FEED:    if (beat && (beat_cnt == k_q - KW'(1))) nxt = DRAIN;
         DRAIN:   if (drn_cnt == DW'(2 * N - 2)) nxt = READOUT;
         READOUT: if (hs && last_el) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         k_q      <= '0;
         beat_cnt <= '0;
         drn_cnt  <= '0;
         row      <= '0;
         col      <= '0;
         done_q   <= 1'b0;
      end else begin
         state  <= nxt;
         done_q <= hs && last_el;
         if (state == IDLE && nxt == CLEAR) k_q <= k_len;
         if (state == CLEAR)  beat_cnt <= '0;
         else if (beat)       beat_cnt <= beat_cnt + KW'(1);
         drn_cnt <= (state == DRAIN) ? drn_cnt + DW'(1) : '0;
         // Row-major walk; the final element returns both indices to zero.
         if (state == CLEAR) begin
            row <= '0;
            col <= '0;
         end else if (hs) begin
            if (last_el) begin
               row <= '0;
               col <= '0;
            end else if (col == RW'(N - 1)) begin
               col <= '0;
               row <= row + RW'(1);
            end else begin
               col <= col + RW'(1);
            end
         end
      end
   end

   assign busy      = (state != IDLE) || done_q;
   assign in_ready  = (state == FEED);
   assign out_valid = (state == READOUT);
   assign out_last  = out_valid && last_el;
   assign out_data  = acc[row][col];
   assign out_row   = row;
   assign out_col   = col;
   assign done      = done_q;

   // Lane i is delayed i cycles so that A[i][k] and B[k][j] meet in PE(i,j) together.
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign w_lane[i] = beat ? in_west[i*DATA_W +: DATA_W]  : '0;
      assign n_lane[i] = beat ? in_north[i*DATA_W +: DATA_W] : '0;
      if (i == 0) begin : g_nodly
         assign w_sk[i] = w_lane[i];
         assign n_sk[i] = n_lane[i];
      end else begin : g_dly
         logic [i-1:0][DATA_W-1:0] wp, np;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wp <= '0;
               np <= '0;
            end else if (pe_clr) begin
               wp <= '0;
               np <= '0;
            end else begin
               wp[0] <= w_lane[i];
               np[0] <= n_lane[i];
               for (int d = 1; d < i; d++) begin
                  wp[d] <= wp[d-1];
                  np[d] <= np[d-1];
               end
            end
         end
         assign w_sk[i] = wp[i-1];
         assign n_sk[i] = np[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [DATA_W-1:0] a_i, b_i, a_o, b_o;

         if (j == 0) begin : g_aw
            assign a_i = w_sk[i];
         end else begin : g_ap
            assign a_i = a_pass[i][j-1];
         end
         if (i == 0) begin : g_bn
            assign b_i = n_sk[j];
         end else begin : g_bp
            assign b_i = b_pass[i-1][j];
         end
         if (j < N - 1) begin : g_ao
            assign a_pass[i][j] = a_o;
         end else begin : g_ae
            assign a_east_unused[i] = a_o;
         end
         if (i < N - 1) begin : g_bo
            assign b_pass[i][j] = b_o;
         end else begin : g_be
            assign b_south_unused[j] = b_o;
         end

         systolic_mac_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (pe_clr),
            .en    (pe_en),
            .a_in  (a_i),
            .b_in  (b_i),
            .a_out (a_o),
            .b_out (b_o),
            .acc   (acc[i][j])
         );
      end
   end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: a reference matmul fills a scoreboard queue
// that is drained against the serial result stream.
module tb_systolic_mm_engine;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int KM = 16;
   localparam int KW = $clog2(KM + 1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [KW-1:0]   k_len = '0;
   logic            busy;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*DW-1:0] in_west = '0;
   logic [N*DW-1:0] in_north = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [AW-1:0]   out_data;
   logic [1:0]      out_row, out_col;
   logic            out_last;
   logic            done;

   systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_west(in_west), .in_north(in_north),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0] d;
      logic [1:0]    r;
      logic [1:0]    c;
      logic          l;
   } exp_t;

   logic [DW-1:0] A [N][KM];
   logic [DW-1:0] B [KM][N];
   exp_t          q [$];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_expected(input int k);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            logic [AW-1:0] s;
            logic signed [AW-1:0] p;
            s = '0;
            for (int kk = 0; kk < k; kk++) begin
               p = $signed(A[i][kk]) * $signed(B[kk][j]);
               s = s + p;
            end
            q.push_back('{s, 2'(i), 2'(j), (i == N - 1) && (j == N - 1)});
         end
   endtask

   task automatic run_job(input string tag, input int k, input bit gap, input bit rnd_rdy,
                          input bit hold_start);
      int  kk, guard, t_beat;
      bit  first_seen;
      push_expected(k);
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(k);
      @(negedge clk);
      check({tag, "_busy_start"}, busy, 1);
      check({tag, "_ready_clear"}, in_ready, 0);
      if (hold_start) k_len = KW'(1);
      else start = 1'b0;
      kk = 0; guard = 0; t_beat = 0;
      while (kk < k && guard < 200) begin
         in_valid = gap ? guard[0] : 1'b1;
         for (int i = 0; i < N; i++) begin
            in_west[i*DW +: DW]  = A[i][kk];
            in_north[i*DW +: DW] = B[kk][i];
         end
         if (in_valid && in_ready) begin
            kk++;
            t_beat = cyc;
         end
         guard++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, "_beats"}, kk, k);
      guard = 0; first_seen = 1'b0;
      while (q.size() > 0 && guard < 1000) begin
         if (out_valid) begin
            if (!first_seen) check({tag, "_latency"}, cyc - t_beat, 2 * N);
            first_seen = 1'b1;
            check({tag, "_data"}, out_data, q[0].d);
            check({tag, "_row"},  out_row,  q[0].r);
            check({tag, "_col"},  out_col,  q[0].c);
            check({tag, "_last"}, out_last, q[0].l);
         end
         out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) void'(q.pop_front());
         guard++;
         @(negedge clk);
      end
      check({tag, "_left"}, q.size(), 0);
      out_ready = 1'b0;
      start = 1'b0;
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_done"}, busy, 1);
      check({tag, "_valid_done"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_done_end"}, done, 0);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic load_t1();
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < N; kk++) begin
            A[i][kk] = (i == kk) ? 16'd1 : 16'd0;
            B[kk][i] = 16'(kk * N + i + 1);
         end
   endtask

   initial begin
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < KM; kk++) begin
            A[i][kk] = '0;
            B[kk][i] = '0;
         end

      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_done", done, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_row", out_row, 0);
      check("rst_out_col", out_col, 0);
      rst_n = 1'b1;

      load_t1();
      run_job("t1", 4, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < 4; kk++) begin
            A[i][kk] = 16'hFFFF;
            B[kk][i] = 16'd2;
         end
      run_job("t2", 4, 1'b0, 1'b0, 1'b0);

      load_t1();
      run_job("t3", 4, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < KM; kk++) begin
            A[i][kk] = 16'h7FFF;
            B[kk][i] = 16'h7FFF;
         end
      run_job("t4", 16, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      start = 1'b1;
      k_len = '0;
      @(negedge clk);
      start = 1'b0;
      check("t5_k0_busy", busy, 0);
      check("t5_k0_ready", in_ready, 0);
      @(negedge clk);
      check("t5_k0_busy2", busy, 0);
      load_t1();
      run_job("t5", 4, 1'b0, 1'b1, 1'b1);

      @(negedge clk);
      start = 1'b1;
      k_len = KW'(4);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_mid_ready", in_ready, 1);
      rst_n = 1'b0;
      #1;
      check("t6_abort_busy", busy, 0);
      check("t6_abort_ready", in_ready, 0);
      check("t6_abort_valid", out_valid, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_job("t6", 4, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
